// File: rtl/bus_slave_port.sv
// Windowed bus responder: wait-state insertion, single-word RAM access, one-cycle ready.
// Optional write protect (wp/err ports) is enabled by defining BUS_SLAVE_WP_EN.
module bus_slave_port #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH_LOG2 = 6,
  parameter logic [ADDR_W-1:0] BASE = 16'h8000,
  parameter int WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_oe,
`ifdef BUS_SLAVE_WP_EN
  input  logic              wp,
  output logic              err,
`endif
  output logic              ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_TURN
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  wr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     ram [DEPTH];

  logic                  hit;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic                  go_ack;
  logic                  ack_wr;
  logic [DEPTH_LOG2-1:0] ack_idx;
  logic                  commit;
`ifdef BUS_SLAVE_WP_EN
  logic                  wp_q;
  logic                  ack_wp;
`endif

  assign hit = addr[ADDR_W-1:DEPTH_LOG2] == BASE[ADDR_W-1:DEPTH_LOG2];
  assign idx_in = addr[DEPTH_LOG2-1:0];

  // With no wait states ACK is entered straight from the IDLE sample,
  // so the response must come from the live bus inputs.
  always_comb begin
    go_ack = 1'b0;
    ack_wr = wr_q;
    ack_idx = idx_q;
`ifdef BUS_SLAVE_WP_EN
    ack_wp = wp_q;
`endif
    unique case (state)
      S_IDLE: begin
        go_ack = req && hit && (WAIT == 0);
        ack_wr = wr;
        ack_idx = idx_in;
`ifdef BUS_SLAVE_WP_EN
        ack_wp = wp;
`endif
      end
      S_WAIT: go_ack = req && (cnt == 4'd1);
      default: go_ack = 1'b0;
    endcase
  end

  always_comb begin
    commit = (state == S_ACK) && wr_q;
`ifdef BUS_SLAVE_WP_EN
    commit = commit && !wp_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      idx_q <= '0;
      wr_q <= 1'b0;
      wdata_q <= '0;
      ready <= 1'b0;
      rdata_oe <= 1'b0;
      rdata <= '0;
`ifdef BUS_SLAVE_WP_EN
      wp_q <= 1'b0;
      err <= 1'b0;
`endif
    end else begin
      ready <= go_ack;
      rdata_oe <= go_ack && !ack_wr;
      rdata <= (go_ack && !ack_wr) ? ram[ack_idx] : '0;
`ifdef BUS_SLAVE_WP_EN
      err <= go_ack && ack_wr && ack_wp;
`endif
      unique case (state)
        S_IDLE: begin
          if (req && hit) begin
            idx_q <= idx_in;
            wr_q <= wr;
            wdata_q <= wdata;
`ifdef BUS_SLAVE_WP_EN
            wp_q <= wp;
`endif
            cnt <= 4'(WAIT);
            state <= (WAIT == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (cnt == 4'd1) begin
            state <= S_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: state <= S_TURN;
        S_TURN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset in ACK must suppress the commit, hence the explicit gate.
  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      ram[idx_q] <= wdata_q;
    end
  end

endmodule

// File: doc/bus_slave_port.md
# bus_slave_port

Memory-mapped bus responder: the slave end of the DMA bus whose arbiter grants one master at a time and holds that grant until the slave asserts `ready`. The block decodes the bus address against its base window, inserts a fixed number of wait states, and services a single read or write into a local RAM. It then pulses `ready` for exactly one cycle, which releases the arbiter. It sits on the shared bus alongside other slaves; only the slave whose window matches responds.

## Interface
Parameters:
- `ADDR_W`, 16, bus address width
- `DATA_W`, 8, bus data width
- `DEPTH_LOG2`, 6, log2 of local RAM words; window size = 2^DEPTH_LOG2
- `BASE`, 16'h8000, window base; must be aligned to 2^DEPTH_LOG2
- `WAIT`, 2, wait states inserted before `ready` (0..15)

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  clock, all state on rising edge
- `reset`  input  1  synchronous active-high reset
- `req`  input  1  bus cycle active (arbiter `req`)
- `addr`  input  ADDR_W  bus address from granted master
- `wr`  input  1  1 = write, 0 = read
- `wdata`  input  DATA_W  write data
- `rdata`  output  DATA_W  read data, valid only while `rdata_oe`=1
- `rdata_oe`  output  1  drive enable for shared data bus
- `ready`  output  1  one-cycle completion pulse to arbiter/master
- `wp`  input  1  write protect (only with `BUS_SLAVE_WP_EN`)
- `err`  output  1  protection error, pulses with `ready` (only with `BUS_SLAVE_WP_EN`)

## Operation
- Hit: `addr[ADDR_W-1:DEPTH_LOG2] == BASE[ADDR_W-1:DEPTH_LOG2]`. Index = `addr[DEPTH_LOG2-1:0]`.
- States: IDLE, WAIT, ACK, TURN.
- IDLE: if `req` & hit, latch `addr` index, `wr`, `wdata`; load counter = WAIT. Go to WAIT if WAIT>0, else ACK. If there is a miss or no `req`, stay in IDLE.
- WAIT: counter decrements each cycle; at counter==1 go to ACK. If `req` drops, abort to IDLE: no write, no `ready`.
- ACK: `ready`=1 for this cycle only.
  - Read: `rdata` = RAM[index] and `rdata_oe`=1.
  - Write: RAM[index] <= latched `wdata` at the edge ending ACK.
  - Next state is always TURN.
- TURN: one dead cycle; `req` is ignored. This prevents re-servicing a master that still holds its request. Next state is IDLE.
- Inputs changing after the IDLE sample are ignored; the latched values are used.
- The RAM is not reset. Outside ACK, `rdata`=0 and `rdata_oe`=0.

## Timing
- Reset values: state IDLE, `ready`=0, `rdata_oe`=0, `rdata`=0, `err`=0, counter=0.
- Latency: when `req` & hit is sampled at edge N, `ready` is high in cycle N+1+WAIT. WAIT=0 gives `ready` in the cycle after sampling.
- Throughput: one transaction per WAIT+3 cycles (sample, WAIT cycles, ACK, TURN).
- `ready`, `rdata_oe` and `err` are registered outputs, glitch-free, and high for exactly one cycle.
- Reset asserted in WAIT or ACK: the transaction is abandoned, no RAM write occurs, and outputs take reset values at that edge.
- `req` high during TURN is not sampled; the earliest next sample is the first IDLE edge.
- Index is DEPTH_LOG2 bits wide; there is no wrap or overflow, because out-of-window addresses are misses.

## Configuration
- `BUS_SLAVE_WP_EN` defined:
  - Adds `wp` and `err`; `wp` is sampled with the other inputs in IDLE.
  - A write latched with `wp`=1 still completes the handshake, so `ready` still pulses and the bus never hangs.
  - The RAM is not modified and `err`=1 in the ACK cycle.
  - Reads ignore `wp` and give `err`=0.
- Not defined: no `wp`/`err` ports; all writes commit.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, `req`=0 → `ready`/`rdata_oe`/`rdata` stay 0 for 20 cycles.
- Write/read, WAIT=2:
  - Write 8'hA5 to 16'h8003 → `ready` high exactly 3 cycles after the sample edge, for one cycle.
  - Read 16'h8003 → `rdata`=8'hA5 with `rdata_oe`=1 in the `ready` cycle.
- Miss: `req`=1, `addr`=16'h4003 for 10 cycles → `ready` never asserts; RAM[3] unchanged.
- Held request: `req` held high continuously at a hit → TURN forces `ready` pulses spaced WAIT+3 = 5 cycles apart, never back-to-back.
- Abort and reset:
  - `req` dropped in the first WAIT cycle of a write 8'h3C → no `ready`; a later read returns the old value.
  - `reset` asserted in the ACK cycle of a write → RAM unchanged.
- With `BUS_SLAVE_WP_EN`:
  - Write 8'hFF with `wp`=1 → `ready`=1 and `err`=1 in the same cycle; readback returns the prior value.
  - The same write with `wp`=0 → `err`=0 and readback returns 8'hFF.
